sram_burst_ctrl: RTL
====================

SRAM_BURST_CTRL -- requirements
Module: sram_burst_ctrl

Interface
REQ-001 Parameter ADDR_W, default 18: SRAM word-address width.
REQ-002 Parameter DATA_W, default 16: data width; SHALL be a multiple of 8; NB = DATA_W/8 byte lanes.
REQ-003 Parameter BLEN_W, default 3: burst-length field width; bursts are 1..2^BLEN_W beats.
REQ-004 Parameter WAIT_CYC, default 1, legal range 0..15: extra strobe cycles per beat.
REQ-005 clk_w  in  1  sole clock, rising edge.
REQ-006 reset  in  1  asynchronous, active-high.
REQ-007 req  in  1  command request.
REQ-008 rw  in  1  1=read, 0=write.
REQ-009 addr  in  ADDR_W  burst start word address.
REQ-010 blen  in  BLEN_W  beats minus one.
REQ-011 be  in  NB  byte enables, active-high, applied to every beat.
REQ-012 data_f2s  in  DATA_W  write data; valid whenever wd_ack=1.
REQ-013 wd_ack  out  1  data_f2s consumed this cycle.
REQ-014 ready  out  1  controller idle; command accepted when req&ready.
REQ-015 data_s2f  out  DATA_W  registered read data.
REQ-016 rvalid  out  1  one-cycle pulse per read beat; data_s2f valid.
REQ-017 ad  out  ADDR_W; we_n, oe_n, ce_n  out  1 each; be_n  out  NB: SRAM strobes, active-low.
REQ-018 dio  inout  DATA_W  SRAM data bus.

Function
REQ-019 States SHALL be IDLE, RD, WR, WREC, TURN; ready=1 only in IDLE.
REQ-020 On the edge with req&ready, addr/rw/blen/be SHALL be captured; IDLE->RD if rw=1, else IDLE->WR; req while not ready SHALL be ignored, not queued.
REQ-021 A WAIT_CYC-bit-capable beat counter SHALL hold RD or WR for exactly WAIT_CYC+1 cycles per beat.
REQ-022 Read: oe_n=0 continuously through all beats; dio sampled on the last RD edge of each beat into data_s2f, rvalid=1 the following cycle; first rvalid at acceptance edge + WAIT_CYC+1 cycles.
REQ-023 After the final read beat, one TURN cycle (oe_n=1, dio hi-Z) SHALL precede IDLE; read burst total = beats*(WAIT_CYC+1)+1 cycles.
REQ-024 Write: WR drives we_n=0 and dio for WAIT_CYC+1 cycles, then WREC one cycle with we_n=1, dio still driven, ad stable (data hold); WREC->WR for the next beat or ->IDLE after the last; total = beats*(WAIT_CYC+2) cycles.
REQ-025 wd_ack SHALL be 1 in the acceptance cycle of a write and in each WREC cycle except the last beat's; data_f2s sampled on those edges.
REQ-026 ad SHALL equal start address + beat index, wrapping modulo 2^ADDR_W (e.g. 0x3FFFF -> 0x00000).
REQ-027 ce_n=0 and be_n=~be in all non-IDLE states; ce_n=1, be_n all-ones in IDLE.
REQ-028 we_n, oe_n, ce_n, be_n, ad and the dio output enable SHALL be driven directly from flops (glitch-free).
REQ-029 we_n=0 and oe_n=0 SHALL never coexist; dio SHALL be driven only in WR/WREC and hi-Z otherwise.
REQ-030 be=0 SHALL still execute the full burst timing with be_n all-ones.

Reset
REQ-031 reset SHALL asynchronously force IDLE, we_n=oe_n=ce_n=1, be_n all-ones, dio hi-Z, ad=0, data_s2f=0, rvalid=0, wd_ack=0, ready=1.
REQ-032 reset mid-burst SHALL abort immediately with no further rvalid or wd_ack; the first command after release starts cleanly.

Structure
REQ-033 Package sram_ctrl_pkg SHALL hold the state enum and default ADDR_W/DATA_W/BLEN_W/WAIT_CYC constants.
REQ-034 The per-beat wait counter SHALL be sub-module sram_beat_timer (load, count, done).

Verification
REQ-035 WAIT_CYC=1, read addr=0x00010 blen=3 -> 4 rvalid pulses every 2 cycles, first at accept+2, ad 0x10..0x13, oe_n low 8 cycles, then TURN, ready after 9 cycles.
REQ-036 WAIT_CYC=0, write addr=0x3FFFE blen=2 data 0xA001,0xA002,0xA003 -> ad 0x3FFFE,0x3FFFF,0x00000, we_n low 1 of every 2 cycles, 3 wd_ack, 6 cycles total.
REQ-037 Write be=2'b10 then read back same address -> be_n=2'b01 on write; read returns model data with only upper byte changed.
REQ-038 req held high during burst with changing addr -> ignored; next command accepted only when ready=1.
REQ-039 reset asserted at beat 2 of a 4-beat write -> we_n=1 and dio hi-Z immediately, no further wd_ack; subsequent read completes correctly.
REQ-040 All tests: assertion that we_n and oe_n are never both 0 and dio is never driven while oe_n=0.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// Shared types and default sizing for the SRAM burst controller.
// Imported by the controller top and its beat timer.
package sram_ctrl_pkg;

  localparam int ADDR_W_DEF   = 18;
  localparam int DATA_W_DEF   = 16;
  localparam int BLEN_W_DEF   = 3;
  localparam int WAIT_CYC_DEF = 1;

  // wide enough for the largest legal wait count (15)
  localparam int TMR_W = 4;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    WR   = 3'd2,
    WREC = 3'd3,
    TURN = 3'd4
  } state_e;

endpackage

// File: rtl/sram_beat_timer.sv
// Per-beat strobe timer: load arms WAIT_CYC, count runs it down,
// done flags the final cycle of the current beat.
module sram_beat_timer
  import sram_ctrl_pkg::*;
#(
  parameter int WAIT_CYC = WAIT_CYC_DEF
) (
  input  logic clk_w,
  input  logic reset,
  input  logic load,
  input  logic count,
  output logic done
);

  localparam logic [TMR_W-1:0] T_ONE = TMR_W'(1);
  localparam logic [TMR_W-1:0] T_LD  = TMR_W'(WAIT_CYC);

  logic [TMR_W-1:0] cnt_q;
  logic [TMR_W-1:0] cnt_d;

  assign done = (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    unique case (1'b1)
      load:          cnt_d = T_LD;
      count && !done: cnt_d = cnt_q - T_ONE;
      default:       cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_w or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sram_burst_ctrl.sv
// Burst controller for an asynchronous SRAM: timed read/write beats,
// write recovery, read turnaround, all strobes launched from flops.
module sram_burst_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int BLEN_W   = BLEN_W_DEF,
  parameter int WAIT_CYC = WAIT_CYC_DEF
) (
  input  logic                clk_w,
  input  logic                reset,
  input  logic                req,
  input  logic                rw,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [BLEN_W-1:0]   blen,
  input  logic [DATA_W/8-1:0] be,
  input  logic [DATA_W-1:0]   data_f2s,
  output logic                wd_ack,
  output logic                ready,
  output logic [DATA_W-1:0]   data_s2f,
  output logic                rvalid,
  output logic [ADDR_W-1:0]   ad,
  output logic                we_n,
  output logic                oe_n,
  output logic                ce_n,
  output logic [DATA_W/8-1:0] be_n,
  inout  wire  [DATA_W-1:0]   dio
);

  localparam int NB = DATA_W / 8;
  localparam logic [ADDR_W-1:0] A_ONE = ADDR_W'(1);
  localparam logic [BLEN_W-1:0] B_ONE = BLEN_W'(1);

  state_e state_q;
  state_e state_d;

  logic [ADDR_W-1:0] ad_q;
  logic [ADDR_W-1:0] ad_d;
  logic [BLEN_W-1:0] left_q;
  logic [BLEN_W-1:0] left_d;
  logic [NB-1:0]     be_q;
  logic [NB-1:0]     be_d;
  logic [DATA_W-1:0] wdat_q;
  logic [DATA_W-1:0] wdat_d;
  logic [DATA_W-1:0] rdat_q;
  logic [DATA_W-1:0] rdat_d;
  logic              rvalid_q;
  logic              rvalid_d;
  logic              we_n_q;
  logic              we_n_d;
  logic              oe_n_q;
  logic              oe_n_d;
  logic              ce_n_q;
  logic              ce_n_d;
  logic [NB-1:0]     be_n_q;
  logic [NB-1:0]     be_n_d;
  logic              doe_q;
  logic              doe_d;

  logic          accept;
  logic          last;
  logic          done;
  logic          adv;
  logic          cap;
  logic          tmr_load;
  logic          tmr_count;
  logic [NB-1:0] be_src;

  assign ready  = (state_q == IDLE);
  assign accept = req && ready;
  assign last   = (left_q == '0);

  // next beat starts after a read beat or a write recovery
  assign adv = ((state_q == RD) && done && !last)
            || ((state_q == WREC) && !last);
  assign cap = (state_q == RD) && done;

  assign wd_ack = !reset
               && ((accept && !rw)
               || ((state_q == WREC) && !last));

  assign tmr_load  = accept || adv;
  assign tmr_count = (state_q == RD) || (state_q == WR);
  assign be_src    = accept ? be : be_q;

  sram_beat_timer #(
    .WAIT_CYC (WAIT_CYC)
  ) u_timer (
    .clk_w (clk_w),
    .reset (reset),
    .load  (tmr_load),
    .count (tmr_count),
    .done  (done)
  );

  always_ff @(posedge clk_w or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = rw ? RD : WR;
      RD:   if (done) state_d = last ? TURN : RD;
      WR:   if (done) state_d = WREC;
      WREC: state_d = last ? IDLE : WR;
      TURN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // strobe values for the coming cycle, keyed on the next state
  always_comb begin
    we_n_d = 1'b1;
    oe_n_d = 1'b1;
    ce_n_d = 1'b0;
    doe_d  = 1'b0;
    be_n_d = ~be_src;
    unique case (state_d)
      IDLE: begin
        ce_n_d = 1'b1;
        be_n_d = '1;
      end
      RD: oe_n_d = 1'b0;
      WR: begin
        we_n_d = 1'b0;
        doe_d  = 1'b1;
      end
      WREC: doe_d = 1'b1;
      TURN: oe_n_d = 1'b1;
      default: ce_n_d = 1'b1;
    endcase
  end

  always_comb begin
    ad_d   = ad_q;
    left_d = left_q;
    unique case (1'b1)
      accept: begin
        ad_d   = addr;
        left_d = blen;
      end
      adv: begin
        ad_d   = ad_q + A_ONE;
        left_d = left_q - B_ONE;
      end
      default: begin
        ad_d   = ad_q;
        left_d = left_q;
      end
    endcase
  end

  always_comb begin
    be_d     = accept ? be : be_q;
    wdat_d   = wd_ack ? data_f2s : wdat_q;
    rdat_d   = cap ? dio : rdat_q;
    rvalid_d = cap;
  end

  always_ff @(posedge clk_w or posedge reset) begin
    if (reset) begin
      ad_q     <= '0;
      left_q   <= '0;
      be_q     <= '0;
      wdat_q   <= '0;
      rdat_q   <= '0;
      rvalid_q <= 1'b0;
      we_n_q   <= 1'b1;
      oe_n_q   <= 1'b1;
      ce_n_q   <= 1'b1;
      be_n_q   <= '1;
      doe_q    <= 1'b0;
    end else begin
      ad_q     <= ad_d;
      left_q   <= left_d;
      be_q     <= be_d;
      wdat_q   <= wdat_d;
      rdat_q   <= rdat_d;
      rvalid_q <= rvalid_d;
      we_n_q   <= we_n_d;
      oe_n_q   <= oe_n_d;
      ce_n_q   <= ce_n_d;
      be_n_q   <= be_n_d;
      doe_q    <= doe_d;
    end
  end

  assign ad       = ad_q;
  assign we_n     = we_n_q;
  assign oe_n     = oe_n_q;
  assign ce_n     = ce_n_q;
  assign be_n     = be_n_q;
  assign data_s2f = rdat_q;
  assign rvalid   = rvalid_q;
  assign dio      = doe_q ? wdat_q : {DATA_W{1'bz}};

endmodule
